dmem_mmio: RTL and testbench

- Data-side memory block directly downstream of the single-cycle MIPS core.
- Consumes the core's memwrite, aluout (address) and writedata, and returns readdata in the same cycle.
- Contains a word-addressed data RAM plus a small memory-mapped peripheral window: GPIO, a free-running cycle counter and a compare timer with interrupt flag.

---
 rtl/dmem_mmio.sv | 145 ++++++++++++++
 tb/tb_dmem_mmio.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// Data-side memory for the single-cycle MIPS core: word RAM plus an MMIO window (GPIO, cycle counter, compare timer).
// The compare timer and irq are only built when DMEM_MMIO_TIMER_EN is defined; otherwise they read 0 and irq is tied low.
module dmem_mmio #(
    parameter int RAM_AW = 6,
    parameter int GPIO_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwrite,
    input  logic [31:0]       addr,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              irq
);

    localparam logic [5:0] OFF_GPIO_OUT = 6'h00;
    localparam logic [5:0] OFF_GPIO_IN  = 6'h01;
    localparam logic [5:0] OFF_CYCLE    = 6'h02;
`ifdef DMEM_MMIO_TIMER_EN
    localparam logic [5:0] OFF_TCMP     = 6'h03;
    localparam logic [5:0] OFF_TCTRL    = 6'h04;
    localparam logic [5:0] OFF_TCNT     = 6'h05;
`endif

    logic              is_mmio;
    logic [5:0]        off;
    logic              mmio_we;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_idx;

    // Byte lane and the upper offset byte play no part in decode.
    logic unused_addr;
    assign unused_addr = &{1'b0, addr[15:8], addr[1:0]};

    assign is_mmio = (addr[31:16] == 16'hFFFF);
    assign off     = addr[7:2];
    assign mmio_we = memwrite & is_mmio;
    assign ram_we  = memwrite & ~is_mmio;
    assign ram_idx = addr[RAM_AW+1:2];

    logic [31:0] mem_q [2**RAM_AW];

    always_ff @(posedge clk) begin
        if (ram_we) mem_q[ram_idx] <= writedata;
    end

    logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
    logic [GPIO_W-1:0] sync1_q, sync2_q;
    logic [31:0]       cycle_q, cycle_d;

    always_comb begin
        gpio_out_d = gpio_out_q;
        if (mmio_we && off == OFF_GPIO_OUT) gpio_out_d = writedata[GPIO_W-1:0];
        cycle_d = cycle_q + 32'd1;
        if (mmio_we && off == OFF_CYCLE) cycle_d = writedata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            cycle_q    <= '0;
        end else begin
            gpio_out_q <= gpio_out_d;
            sync1_q    <= gpio_in;
            sync2_q    <= sync1_q;
            cycle_q    <= cycle_d;
        end
    end

    assign gpio_out = gpio_out_q;

`ifdef DMEM_MMIO_TIMER_EN
    logic        en_q, en_d;
    logic        auto_q, auto_d;
    logic        flag_q, flag_d;
    logic [31:0] cmp_q, cmp_d;
    logic [31:0] cnt_q, cnt_d;
    logic        wr_cmp, wr_ctrl, wr_cnt, match;

    assign wr_cmp  = mmio_we && off == OFF_TCMP;
    assign wr_ctrl = mmio_we && off == OFF_TCTRL;
    assign wr_cnt  = mmio_we && off == OFF_TCNT;
    // A software load of the count pre-empts the compare for that cycle.
    assign match   = en_q && !wr_cnt && (cnt_q == cmp_q);

    always_comb begin
        cmp_d  = wr_cmp ? writedata : cmp_q;
        auto_d = wr_ctrl ? writedata[2] : auto_q;
        en_d   = en_q;
        if (wr_ctrl)               en_d = writedata[0];
        else if (match && !auto_q) en_d = 1'b0;
        flag_d = flag_q;
        if (match)                          flag_d = 1'b1;
        else if (wr_ctrl && writedata[1])   flag_d = 1'b0;
        cnt_d = cnt_q;
        if (wr_cnt)       cnt_d = writedata;
        else if (match)   cnt_d = auto_q ? 32'd0 : cnt_q;
        else if (en_q)    cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q   <= 1'b0;
            auto_q <= 1'b0;
            flag_q <= 1'b0;
            cmp_q  <= '0;
            cnt_q  <= '0;
        end else begin
            en_q   <= en_d;
            auto_q <= auto_d;
            flag_q <= flag_d;
            cmp_q  <= cmp_d;
            cnt_q  <= cnt_d;
        end
    end

    assign irq = flag_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        if (!is_mmio) begin
            readdata = mem_q[ram_idx];
        end else begin
            case (off)
                OFF_GPIO_OUT: readdata = 32'(gpio_out_q);
                OFF_GPIO_IN:  readdata = 32'(sync2_q);
                OFF_CYCLE:    readdata = cycle_q;
`ifdef DMEM_MMIO_TIMER_EN
                OFF_TCMP:     readdata = cmp_q;
                OFF_TCTRL:    readdata = {29'd0, auto_q, flag_q, en_q};
                OFF_TCNT:     readdata = cnt_q;
`endif
                default:      readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
module tb_dmem_mmio;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        irq;

    dmem_mmio #(.RAM_AW(6), .GPIO_W(8)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr),
        .writedata(writedata), .readdata(readdata), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .irq(irq)
    );

    always #5 clk = ~clk;

    localparam int K_RD = 0, K_GPIO = 1, K_IRQ = 2;

    int          q_kind[$];
    logic [31:0] q_exp[$];
    string       q_name[$];
    int          n_vec = 0;
    int          n_bad = 0;
    bit          done = 1'b0;

    always @(negedge clk) begin
        while (q_kind.size() > 0) begin
            int          k;
            logic [31:0] e, a;
            string       n;
            k = q_kind.pop_front();
            e = q_exp.pop_front();
            n = q_name.pop_front();
            a = (k == K_RD) ? readdata : (k == K_GPIO) ? {24'd0, gpio_out} : {31'd0, irq};
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
            end
        end
    end

    initial begin
        #200000;
        if (!done) begin
            n_bad++;
            $display("FAIL timeout: stimulus did not complete (t=%0t)", $time);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic now_chk(input logic [31:0] a, input logic [31:0] e, input string n);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s (immediate): got %h expected %h (t=%0t)", n, a, e, $time);
        end
    endtask

    task automatic chk(input int k, input logic [31:0] e, input string n);
        q_kind.push_back(k);
        q_exp.push_back(e);
        q_name.push_back(n);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
        addr = a;
        memwrite = 1'b0;
        chk(K_RD, e, n);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        writedata = d;
        memwrite = 1'b1;
        tick();
        memwrite = 1'b0;
    endtask

    initial begin
        reset = 1'b1; memwrite = 1'b0; addr = '0; writedata = '0; gpio_in = 8'h00;
        #2 reset = 1'b0;
        @(posedge clk); #1;

        addr = 32'hFFFF0008; #1;
        now_chk(readdata, 32'h0, "rst_cycle_now");
        now_chk({24'd0, gpio_out}, 32'h0, "rst_gpio_now");
        now_chk({31'd0, irq}, 32'h0, "rst_irq_now");

        rd(32'hFFFF0008, 32'h0, "rst_cycle"); chk(K_GPIO, 32'h0, "rst_gpio"); chk(K_IRQ, 32'h0, "rst_irq");
        tick();
        rd(32'hFFFF0004, 32'h0, "rst_gpio_in");
        tick();
        reset = 1'b1;

        wr(32'h00000010, 32'hDEADBEEF);
        rd(32'h00000010, 32'hDEADBEEF, "ram_rd");    tick();
        rd(32'h00000110, 32'hDEADBEEF, "ram_alias"); tick();
        wr(32'h00000014, 32'h12345678);
        rd(32'h00000114, 32'h12345678, "ram_alias2"); tick();
        rd(32'h00000010, 32'hDEADBEEF, "ram_neighbour"); tick();
        addr = 32'h00000010; writedata = 32'hCAFEF00D; memwrite = 1'b1;
        chk(K_RD, 32'hDEADBEEF, "ram_old_during_wr");
        tick(); memwrite = 1'b0;
        rd(32'h00000010, 32'hCAFEF00D, "ram_new_next"); tick();
        wr(32'h00000020, 32'h55AA55AA);

        wr(32'hFFFF0000, 32'h000001A5);
        rd(32'hFFFF0000, 32'h000000A5, "gpio_out_rd"); chk(K_GPIO, 32'hA5, "gpio_out_pin");
        gpio_in = 8'h3C;
        tick();
        rd(32'hFFFF0004, 32'h0, "gpio_in_lat1"); tick();
        rd(32'hFFFF0004, 32'h3C, "gpio_in_lat2"); tick();

        wr(32'hFFFF0020, 32'hFFFFFFFF);
        rd(32'hFFFF0020, 32'h0, "unmapped_rd"); tick();
        rd(32'hFFFF00FC, 32'h0, "unmapped_rd_hi"); tick();
        rd(32'h00000020, 32'h55AA55AA, "ram_iso_mmio"); chk(K_GPIO, 32'hA5, "gpio_iso"); tick();

        wr(32'hFFFF0008, 32'hFFFFFFFE);
        rd(32'hFFFF0008, 32'hFFFFFFFE, "cycle_ld"); tick();
        rd(32'hFFFF0008, 32'hFFFFFFFF, "cycle_max"); tick();
        rd(32'hFFFF0008, 32'h00000000, "cycle_wrap"); tick();

`ifdef DMEM_MMIO_TIMER_EN
        wr(32'hFFFF000C, 32'd5);
        wr(32'hFFFF0014, 32'd0);
        wr(32'hFFFF0010, 32'h1);
        for (int i = 0; i < 6; i++) begin
            rd(32'hFFFF0014, i, $sformatf("os_cnt%0d", i)); chk(K_IRQ, 32'h0, $sformatf("os_irq%0d", i));
            tick();
        end
        rd(32'hFFFF0014, 32'd5, "os_cnt_hit"); chk(K_IRQ, 32'h1, "os_irq_hit"); tick();
        rd(32'hFFFF0010, 32'h2, "os_ctrl"); tick();
        rd(32'hFFFF0014, 32'd5, "os_cnt_hold"); tick();
        wr(32'hFFFF0010, 32'h2);
        rd(32'hFFFF0010, 32'h0, "w1c_ctrl"); chk(K_IRQ, 32'h0, "w1c_irq"); tick();

        wr(32'hFFFF000C, 32'd3);
        wr(32'hFFFF0014, 32'd0);
        wr(32'hFFFF0010, 32'h5);
        for (int i = 0; i < 4; i++) begin
            rd(32'hFFFF0014, i, $sformatf("ar_cnt%0d", i)); chk(K_IRQ, 32'h0, $sformatf("ar_irq%0d", i));
            tick();
        end
        rd(32'hFFFF0014, 32'd0, "ar_reload"); chk(K_IRQ, 32'h1, "ar_irq_hit"); tick();
        wr(32'hFFFF0010, 32'h7);
        rd(32'hFFFF0014, 32'd2, "ar_cnt2b"); chk(K_IRQ, 32'h0, "ar_clr"); tick();
        wr(32'hFFFF0010, 32'h7);
        rd(32'hFFFF0014, 32'd0, "race_cnt"); chk(K_IRQ, 32'h1, "race_set_wins"); tick();
        rd(32'hFFFF0010, 32'h7, "race_ctrl"); tick();
        wr(32'hFFFF0010, 32'h7);
        wr(32'hFFFF0014, 32'd100);
        rd(32'hFFFF0014, 32'd100, "cntwr_wins"); chk(K_IRQ, 32'h0, "cntwr_nomatch"); tick();
        wr(32'hFFFF0010, 32'h0);
`else
        wr(32'hFFFF000C, 32'd5);
        wr(32'hFFFF0014, 32'd0);
        wr(32'hFFFF0010, 32'h1);
        for (int i = 0; i < 8; i++) begin
            rd(32'hFFFF0010, 32'h0, $sformatf("nt_ctrl%0d", i)); chk(K_IRQ, 32'h0, $sformatf("nt_irq%0d", i));
            tick();
        end
        rd(32'hFFFF000C, 32'h0, "nt_cmp"); tick();
        rd(32'hFFFF0014, 32'h0, "nt_cnt"); tick();
`endif

        reset = 1'b0;
        addr = 32'hFFFF0008; memwrite = 1'b0; #1;
        now_chk(readdata, 32'h0, "arst_cycle_now");
        now_chk({24'd0, gpio_out}, 32'h0, "arst_gpio_now");
        now_chk({31'd0, irq}, 32'h0, "arst_irq_now");
        rd(32'hFFFF0008, 32'h0, "arst_cycle"); chk(K_GPIO, 32'h0, "arst_gpio"); chk(K_IRQ, 32'h0, "arst_irq");
        tick();
        reset = 1'b1;
        rd(32'h00000010, 32'hCAFEF00D, "arst_ram"); tick();
        rd(32'hFFFF0008, 32'h1, "post_rst_cycle"); tick();
        rd(32'hFFFF0004, 32'h3C, "post_rst_sync"); tick();
        tick();

        done = 1'b1;
        if (q_kind.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard: %0d expectations never checked", q_kind.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        if (n_bad != 0) $display("FAIL: %0d miscompares", n_bad);
        else            $display("PASS");
        $finish;
    end

endmodule
